// File: rtl/modn_pkg.sv
// Shared constants and elaboration helpers for the modulo-N counter.
//   MODE_WRAP / MODE_SAT : encodings of the sat_mode input
//   width_ok()           : legality check for a (MOD, WIDTH) pair
package modn_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Legal when 2 <= MOD <= 2^WIDTH, so that MOD-1 fits in the count register.
  function automatic bit width_ok(input int unsigned mod, input int unsigned width);
    longint unsigned cap;
    if (width == 0 || width > 32) return 1'b0;
    cap = 64'd1 << width;
    return (mod >= 2) && (64'(mod) <= cap);
  endfunction

endpackage

// File: rtl/modn_step.sv
// Combinational next-count calculation for one enabled step.
//   i_y        : current count
//   i_up       : 1 = count up, 0 = count down
//   i_sat_mode : boundary behaviour (MODE_WRAP / MODE_SAT)
//   o_next     : count after the step
//   o_wrap     : the step crossed the boundary and wrapped
//   o_ovf      : the step was refused at the boundary (saturate mode)
module modn_step
  import modn_pkg::*;
#(
  parameter int unsigned MOD   = 9,
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_up,
  input  logic             i_sat_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Boundary compare happens before the arithmetic, so +1/-1 never leaves 0..MOD-1.
  always_comb begin
    o_next = i_y;
    o_wrap = 1'b0;
    o_ovf  = 1'b0;
    if (i_up) begin
      if (i_y == MAXV) begin
        if (i_sat_mode == MODE_WRAP) begin
          o_next = '0;
          o_wrap = 1'b1;
        end else begin
          o_ovf = 1'b1;
        end
      end else begin
        o_next = i_y + ONE;
      end
    end else begin
      if (i_y == '0) begin
        if (i_sat_mode == MODE_WRAP) begin
          o_next = MAXV;
          o_wrap = 1'b1;
        end else begin
          o_ovf = 1'b1;
        end
      end else begin
        o_next = i_y - ONE;
      end
    end
  end

endmodule

// File: rtl/modn_sync_counter.sv
// Modulo-MOD up/down counter with wrap or saturate boundary behaviour.
//   clk, rst   : rising-edge clock, asynchronous active-low reset
//   en, up     : step enable and direction
//   sat_mode   : 0 wraps at the boundary, 1 saturates
//   clr, load  : synchronous clear / load (priority clr > load > en)
//   load_val   : load value, clamped to MOD-1
//   y          : registered count
//   tc         : combinational terminal-count indication
//   wrap_p     : registered one-cycle pulse after a wrapping step
//   ovf        : registered sticky flag for a refused saturating step
module modn_sync_counter
  import modn_pkg::*;
#(
  parameter int unsigned MOD   = 9,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf
);

  localparam int unsigned      WEXT = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODX = WEXT'(MOD);

  if (!width_ok(MOD, WIDTH)) begin : g_bad_params
    $error("modn_sync_counter: MOD must be in 2..2^WIDTH");
  end

  logic [WIDTH-1:0] r_y;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_step_y;
  logic             w_step_wrap;
  logic             w_step_ovf;
  logic             w_load_in_range;
  logic [WIDTH-1:0] w_load_y;

  modn_step #(
    .MOD   (MOD),
    .WIDTH (WIDTH)
  ) u_step (
    .i_y        (r_y),
    .i_up       (up),
    .i_sat_mode (sat_mode),
    .o_next     (w_step_y),
    .o_wrap     (w_step_wrap),
    .o_ovf      (w_step_ovf)
  );

  // Compare one bit wider so MOD = 2^WIDTH is representable.
  assign w_load_in_range = ({1'b0, load_val} < MODX);
  assign w_load_y        = w_load_in_range ? load_val : MAXV;

  // Count, pulse and sticky-flag registers with clr > load > en priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clr) begin
      r_y    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (load) begin
      r_y    <= w_load_y;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_y    <= w_step_y;
      r_wrap <= w_step_wrap;
      r_ovf  <= r_ovf | w_step_ovf;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign y      = r_y;
  assign wrap_p = r_wrap;
  assign ovf    = r_ovf;
  assign tc     = en & ((up & (r_y == MAXV)) | (~up & (r_y == '0)));

endmodule

// File: tb/tb_modn_sync_counter.sv
// Scoreboard bench: two counters (MOD=9/WIDTH=5 and MOD=16/WIDTH=4) share
// stimulus; a reference model predicts each cycle and a monitor compares.
module tb_modn_sync_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, sat_mode, clr, load;
  logic [4:0] lv9;
  logic [3:0] lv16;
  logic [4:0] y9;
  logic       tc9, wrap9, ovf9;
  logic [3:0] y16;
  logic       tc16, wrap16, ovf16;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit tc9;  int y9;  bit w9;  bit o9;
    bit tc16; int y16; bit w16; bit o16;
  } exp_t;

  exp_t sb[$];

  // Reference state
  int m9_y = 0;  bit m9_o = 0;
  int m16_y = 0; bit m16_o = 0;

  always #5 clk = ~clk;

  modn_sync_counter #(.MOD(9), .WIDTH(5)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(lv9),
    .y(y9), .tc(tc9), .wrap_p(wrap9), .ovf(ovf9)
  );

  modn_sync_counter #(.MOD(16), .WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(lv16),
    .y(y16), .tc(tc16), .wrap_p(wrap16), .ovf(ovf16)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour of one clock edge for a modulus-m counter.
  function automatic void model(input int m, input int yv, input bit ov,
                                input bit en_, input bit up_, input bit sat_,
                                input bit clr_, input bit ld_, input int lv,
                                output int ny, output bit nw, output bit no);
    ny = yv; nw = 1'b0; no = ov;
    if (clr_) begin
      ny = 0; no = 1'b0;
    end else if (ld_) begin
      ny = (lv < m) ? lv : m - 1;
    end else if (en_) begin
      if (up_ && yv == m - 1) begin
        if (sat_) no = 1'b1; else begin ny = 0; nw = 1'b1; end
      end else if (!up_ && yv == 0) begin
        if (sat_) no = 1'b1; else begin ny = m - 1; nw = 1'b1; end
      end else begin
        ny = up_ ? (yv + 1) % m : (yv - 1);
      end
    end
  endfunction

  function automatic bit exp_tc(input int m, input int yv, input bit en_, input bit up_);
    return en_ && ((up_ && yv == m - 1) || (!up_ && yv == 0));
  endfunction

  // Drive one cycle of inputs and queue the predicted response.
  task automatic cyc(input bit en_, input bit up_, input bit sat_,
                     input bit clr_, input bit ld_, input int lv);
    exp_t e;
    int   lv16i;
    @(posedge clk);
    #2;
    en = en_; up = up_; sat_mode = sat_; clr = clr_; load = ld_;
    lv9   = 5'(lv);
    lv16  = 4'(lv);
    lv16i = lv % 16;
    e.tc9  = exp_tc(9, m9_y, en_, up_);
    e.tc16 = exp_tc(16, m16_y, en_, up_);
    model(9,  m9_y,  m9_o,  en_, up_, sat_, clr_, ld_, lv % 32, m9_y, e.w9, m9_o);
    model(16, m16_y, m16_o, en_, up_, sat_, clr_, ld_, lv16i,   m16_y, e.w16, m16_o);
    e.y9 = m9_y;   e.o9 = m9_o;
    e.y16 = m16_y; e.o16 = m16_o;
    sb.push_back(e);
  endtask

  // Monitor: tc before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tc9", int'(tc9), int'(e.tc9));
        chk("tc16", int'(tc16), int'(e.tc16));
        @(posedge clk);
        #1;
        chk("y9", int'(y9), e.y9);
        chk("wrap9", int'(wrap9), int'(e.w9));
        chk("ovf9", int'(ovf9), int'(e.o9));
        chk("y16", int'(y16), e.y16);
        chk("wrap16", int'(wrap16), int'(e.w16));
        chk("ovf16", int'(ovf16), int'(e.o16));
        chk("range9", int'(y9 < 5'd9), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0;
    clr = 1'b0; load = 1'b0; lv9 = '0; lv16 = '0;
    #3;
    chk("rst_y9", int'(y9), 0);
    chk("rst_wrap9", int'(wrap9), 0);
    chk("rst_ovf9", int'(ovf9), 0);
    chk("rst_y16", int'(y16), 0);
    #5 rst = 1'b1;

    // Free-running up count with wrap on both moduli
    repeat (20) cyc(1, 1, 0, 0, 0, 0);
    // Down count through zero
    cyc(0, 0, 0, 0, 1, 2);
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    // Saturate at top, sticky overflow, then clear
    cyc(0, 1, 1, 0, 1, 7);
    repeat (3) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    // Clamped load, then load with clear
    cyc(0, 1, 0, 0, 1, 20);
    cyc(1, 1, 0, 1, 1, 20);
    // Saturate at bottom
    repeat (2) cyc(1, 0, 1, 0, 0, 0);
    // Mode change takes effect immediately at the top
    cyc(0, 1, 0, 0, 1, 8);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Build y=5 with ovf set, then reset asynchronously between edges
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 8);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    repeat (5) cyc(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_y9", int'(y9), 5);
    chk("pre_rst_ovf9", int'(ovf9), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_y9", int'(y9), 0);
    chk("async_rst_ovf9", int'(ovf9), 0);
    chk("async_rst_wrap9", int'(wrap9), 0);
    chk("async_rst_y16", int'(y16), 0);
    m9_y = 0; m9_o = 1'b0; m16_y = 0; m16_o = 1'b0;
    load = 1'b1; lv9 = 5'd3; lv16 = 4'd3; en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_y9", int'(y9), 0);
    chk("rst_hold_y16", int'(y16), 0);
    load = 1'b0; en = 1'b0;
    #1 rst = 1'b1;
    cyc(1, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      bit c_, l_, e_, u_, s_;
      r  = $urandom_range(0, 99);
      c_ = (r < 4);
      l_ = (r >= 4 && r < 14);
      e_ = ($urandom_range(0, 3) != 0);
      u_ = ($urandom_range(0, 2) != 0);
      s_ = ($urandom_range(0, 3) == 0);
      cyc(e_, u_, s_, c_, l_, int'($urandom_range(0, 31)));
    end

    repeat (4) @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
